// File: rtl/sym_pkg.sv
// Shared definitions for the symbol lookup sequencer.
//   state_t  : sequencer FSM states
//   SYM_TERM : word terminator symbol
//   ROM_LAT  : lookup ROM read latency in CS edges (registered output)
package sym_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0]  SYM_TERM = 8'h00;
  localparam int unsigned ROM_LAT  = 1;

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO buffering input symbols.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_push, i_din    : write request and data (ignored when full)
//   i_pop            : read request (ignored when empty)
//   o_dout           : head entry (combinational read)
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored entries (AW+1 bits)
module sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers are AW bits wide and DEPTH is 2**AW, so they wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sym_lookup_seq.sv
// Upstream sequencer for the 256-entry symbol-code lookup ROM.
// Buffers input symbols, issues each as a ROM address, captures the
// registered ROM output and hands it downstream with an end-of-word flag
// for the terminator symbol 8'h00.
// Ports:
//   CS, cen             : clock, asynchronous active-high reset
//   in_valid/in_data    : input symbol handshake, in_ready = FIFO not full
//   rom_add, rom_data   : ROM address (registered) and registered ROM data
//   out_valid/out_ready : output handshake; out_data code, out_last terminator
//   busy                : FSM active or FIFO non-empty
//   word_cnt            : terminators delivered (only with WORD_COUNT_EN)
// Build option: define WORD_COUNT_EN to add the word_cnt output.
module sym_lookup_seq
  import sym_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       CS,
  input  logic       cen,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] rom_add,
  input  logic [7:0] rom_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
`ifdef WORD_COUNT_EN
  ,
  output logic [7:0] word_cnt
`endif
);

  state_t      r_state;
  logic [7:0]  r_rom_add;
  logic        r_is_term;
  logic [1:0]  r_lat;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_out_last;

  logic [7:0]  w_dout;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_push;
  logic        w_hs;
  logic        w_pop;

  assign w_push = in_valid & ~w_full;
  assign w_hs   = (r_state == HOLD) & out_ready;
  // Pop from IDLE, or straight from HOLD on handshake (back-to-back path).
  assign w_pop  = ~w_empty & ((r_state == IDLE) | w_hs);

  sym_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .i_clk  (CS),
    .i_rst  (cen),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (in_data),
    .o_dout (w_dout),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  always_ff @(posedge CS or posedge cen) begin
    if (cen) begin
      r_state     <= IDLE;
      r_rom_add   <= '0;
      r_is_term   <= 1'b0;
      r_lat       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rom_add <= w_dout;
        r_is_term <= (w_dout == SYM_TERM);
        r_lat     <= '0;
      end
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= ISSUE;
        end
        // Address held stable for ROM_LAT edges while the ROM samples it.
        ISSUE: begin
          if (r_lat == 2'(ROM_LAT - 1)) r_state <= CAPT;
          else                          r_lat   <= r_lat + 2'd1;
        end
        CAPT: begin
          r_out_data  <= rom_data;
          r_out_last  <= r_is_term;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_empty ? IDLE : ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WORD_COUNT_EN
  logic [7:0] r_word_cnt;

  always_ff @(posedge CS or posedge cen) begin
    if (cen) begin
      r_word_cnt <= '0;
    end else if (w_hs && r_out_last) begin
      r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

  assign in_ready  = ~w_full;
  assign rom_add   = r_rom_add;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE) | (w_count != '0);

endmodule

// File: tb/tb_sym_lookup_seq.sv
module tb_sym_lookup_seq;

  logic       CS = 1'b0;
  logic       cen;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] rom_add;
  logic [7:0] rom_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
`ifdef WORD_COUNT_EN
  logic [7:0] word_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit rom_mode = 1'b0;

  logic [7:0] mon_data [$];
  logic       mon_last [$];
  int         mon_cyc  [$];

  sym_lookup_seq #(.DEPTH(4), .AW(2)) dut (
    .CS       (CS),
    .cen      (cen),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rom_add  (rom_add),
    .rom_data (rom_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef WORD_COUNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 CS = ~CS;

  // Registered ROM model: mode 0 -> 02 for nonzero, 00 for zero; mode 1 -> ~addr.
  always @(posedge CS) begin
    if (rom_mode) rom_data <= ~rom_add;
    else          rom_data <= (rom_add == 8'h00) ? 8'h00 : 8'h02;
  end

  // Output handshake monitor.
  always @(posedge CS) begin
    cyc = cyc + 1;
    if (!cen && out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_last.push_back(out_last);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    cen = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge CS);
    @(negedge CS);
    cen = 1'b0;
    mon_data.delete();
    mon_last.delete();
    mon_cyc.delete();
    @(negedge CS);
  endtask

  task automatic push_sym(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 64; i++) begin
      if (in_ready) begin
        @(posedge CS);
        ok = 1'b1;
        break;
      end
      @(negedge CS);
    end
    if (ok) @(negedge CS);
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (mon_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CS);
    end
  endtask

  task automatic test_reset();
    cen = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    @(negedge CS);
    @(negedge CS);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (rom_add !== 8'h00) begin n_bad++; $display("FAIL reset_rom_add: got %h want 00", rom_add); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef WORD_COUNT_EN
    n_cmp++; if (word_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_word_cnt: got %h want 00", word_cnt); end
`endif
  endtask

  task automatic test_latency();
    do_reset();
    rom_mode = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h41;
    @(posedge CS);                 // push edge
    @(negedge CS);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid_e0: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy: got %b want 1", busy); end
    @(negedge CS);                 // after pop edge
    n_cmp++; if (rom_add !== 8'h41) begin n_bad++; $display("FAIL lat_rom_add: got %h want 41", rom_add); end
    @(negedge CS);                 // after ISSUE edge
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid_e2: got %b want 0", out_valid); end
    @(negedge CS);                 // after CAPT edge: 4th edge counting the push
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid_e3: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h02) begin n_bad++; $display("FAIL lat_out_data: got %h want 02", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL lat_out_last: got %b want 0", out_last); end
    @(negedge CS);                 // handshake taken
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid_done: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] syms [3];
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    bit ok;
    syms[0] = 8'h41; syms[1] = 8'h42; syms[2] = 8'h00;
    exp_d[0] = 8'h02; exp_d[1] = 8'h02; exp_d[2] = 8'h00;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
    do_reset();
    rom_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_sym(syms[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_push%0d: accepted %b want 1", i, ok); end
    end
    wait_outputs(3, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout: got %0d outputs want 3", mon_data.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (mon_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, mon_data[i], exp_d[i]); end
        n_cmp++; if (mon_last[i] !== exp_l[i]) begin n_bad++; $display("FAIL b2b_last%0d: got %b want %b", i, mon_last[i], exp_l[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++; if (mon_cyc[i] - mon_cyc[i-1] !== 3) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, mon_cyc[i] - mon_cyc[i-1]); end
      end
    end
`ifdef WORD_COUNT_EN
    @(negedge CS);
    n_cmp++; if (word_cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_word_cnt: got %0d want 1", word_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] syms [6];
    bit acc [6];
    bit ok;
    syms[0] = 8'h10; syms[1] = 8'h20; syms[2] = 8'h30;
    syms[3] = 8'h40; syms[4] = 8'h50; syms[5] = 8'h60;
    do_reset();
    rom_mode = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data = syms[i];
      acc[i] = in_ready;
      @(posedge CS);
      @(negedge CS);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (acc[i] !== (i < 5)) begin n_bad++; $display("FAIL bp_accept%0d: got %b want %b", i, acc[i], (i < 5)); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hEF) begin n_bad++; $display("FAIL bp_data: got %h want ef", out_data); end
    repeat (5) @(negedge CS);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_hold: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hEF) begin n_bad++; $display("FAIL bp_data_hold: got %h want ef", out_data); end
    n_cmp++; if (mon_data.size() !== 0) begin n_bad++; $display("FAIL bp_no_output: got %0d want 0", mon_data.size()); end
    out_ready = 1'b1;
    wait_outputs(5, 100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got %0d outputs want 5", mon_data.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (mon_data[i] !== ~syms[i]) begin n_bad++; $display("FAIL bp_drain%0d: got %h want %h", i, mon_data[i], ~syms[i]); end
      end
    end
    repeat (6) @(negedge CS);
    n_cmp++; if (mon_data.size() !== 5) begin n_bad++; $display("FAIL bp_total: got %0d want 5", mon_data.size()); end
  endtask

  task automatic test_full_release();
    logic [7:0] syms [8];
    bit ok;
    syms[0] = 8'h01; syms[1] = 8'h02; syms[2] = 8'h03; syms[3] = 8'h04;
    syms[4] = 8'h05; syms[5] = 8'h00; syms[6] = 8'h77; syms[7] = 8'h88;
    do_reset();
    rom_mode = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_sym(syms[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fr_push%0d: accepted %b want 1", i, ok); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fr_full: got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(posedge CS);                 // HOLD handshake pops the head
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fr_ready_rise: got %b want 1", in_ready); end
    @(negedge CS);
    for (int i = 5; i < 8; i++) begin
      push_sym(syms[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fr_push%0d: accepted %b want 1", i, ok); end
    end
    wait_outputs(8, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fr_timeout: got %0d outputs want 8", mon_data.size()); end
    repeat (6) @(negedge CS);
    n_cmp++; if (mon_data.size() !== 8) begin n_bad++; $display("FAIL fr_total: got %0d want 8", mon_data.size()); end
    if (mon_data.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (mon_data[i] !== ~syms[i]) begin n_bad++; $display("FAIL fr_data%0d: got %h want %h", i, mon_data[i], ~syms[i]); end
        n_cmp++; if (mon_last[i] !== (syms[i] == 8'h00)) begin n_bad++; $display("FAIL fr_last%0d: got %b want %b", i, mon_last[i], (syms[i] == 8'h00)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rom_mode = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_sym(8'h31 + 8'(i), ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rm_push%0d: accepted %b want 1", i, ok); end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_hold: got %b want 1", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    #2 cen = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge CS);
    @(negedge CS);
    cen = 1'b0;
    out_ready = 1'b1;
    mon_data.delete();
    mon_last.delete();
    mon_cyc.delete();
    repeat (20) @(negedge CS);
    n_cmp++; if (mon_data.size() !== 0) begin n_bad++; $display("FAIL rm_no_output: got %0d want 0", mon_data.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy_after: got %b want 0", busy); end
  endtask

`ifdef WORD_COUNT_EN
  task automatic test_word_wrap();
    bit ok;
    int rej;
    int bad;
    rej = 0;
    bad = 0;
    do_reset();
    rom_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_sym(8'h00, ok);
      if (!ok) rej++;
    end
    n_cmp++; if (rej !== 0) begin n_bad++; $display("FAIL ww_push: rejected %0d want 0", rej); end
    wait_outputs(255, 2000, ok);
    n_cmp++; if (word_cnt !== 8'd255) begin n_bad++; $display("FAIL ww_cnt255: got %0d want 255", word_cnt); end
    wait_outputs(256, 100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ww_timeout: got %0d outputs want 256", mon_data.size()); end
    @(negedge CS);
    n_cmp++; if (word_cnt !== 8'd0) begin n_bad++; $display("FAIL ww_wrap: got %0d want 0", word_cnt); end
    foreach (mon_data[i]) begin
      if (mon_data[i] !== 8'h00 || mon_last[i] !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ww_terms: got %0d non-terminator outputs want 0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_full_release();
    test_reset_mid();
`ifdef WORD_COUNT_EN
    test_word_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
